// File: rtl/program_counter_if.sv
// Fetch-path bus between the PC register and its surrounding pipeline logic.
// Carries the stall line only when PC_STALL_EN is defined.
interface program_counter_if;
  logic [31:0] address;
  logic [31:0] curAddress;
  logic [18:0] condAddr19;
  logic [25:0] brAddr26;
  logic        UncondBr;
  logic        brTaken;
`ifdef PC_STALL_EN
  logic        stall;
`endif

  modport master (
    output curAddress,
    output condAddr19,
    output brAddr26,
    output UncondBr,
    output brTaken,
`ifdef PC_STALL_EN
    output stall,
`endif
    input  address
  );

  modport slave (
    input  curAddress,
    input  condAddr19,
    input  brAddr26,
    input  UncondBr,
    input  brTaken,
`ifdef PC_STALL_EN
    input  stall,
`endif
    output address
  );
endinterface

// File: rtl/program_counter.sv
// Next-PC selection (+4 / CB / B) and the registered fetch address.
// Optional hold-on-stall enabled with the PC_STALL_EN macro.
module program_counter #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  program_counter_if.slave pc
);

  logic [31:0] off;
  logic [31:0] br_tgt;
  logic [31:0] seq_tgt;
  logic [31:0] nxt;

  always_comb begin
    off = '0;
    unique case (1'b1)
      pc.UncondBr:
        off = {{6{pc.brAddr26[25]}}, pc.brAddr26};
      !pc.UncondBr:
        off = {{13{pc.condAddr19[18]}}, pc.condAddr19};
    endcase
  end

  // Word offset to byte offset; top two bits fall off.
  assign br_tgt  = pc.curAddress + {off[29:0], 2'b00};
  assign seq_tgt = pc.curAddress + 32'd4;
  assign nxt     = pc.brTaken ? br_tgt : seq_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc.address <= RESET_ADDR;
`ifdef PC_STALL_EN
    end else if (pc.stall) begin
      pc.address <= pc.address;
`endif
    end else begin
      pc.address <= nxt;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: expected PCs queued at drive time,
// popped and compared one cycle later.
module tb_program_counter;

  logic clk;
  logic rst;
  program_counter_if pc ();

  program_counter #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .pc  (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk;
  int npass;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic logic [31:0] model(input logic [31:0] cur,
    input logic [18:0] c19, input logic [25:0] b26,
    input logic ub, input logic bt);
    logic signed [31:0] w;
    if (!bt) return cur + 32'd4;
    w = ub ? 32'(signed'(b26)) : 32'(signed'(c19));
    return cur + 32'(w * 4);
  endfunction

  task automatic step(input string tag, input logic [31:0] cur,
    input logic [18:0] c19, input logic [25:0] b26,
    input logic ub, input logic bt, input logic rs,
    input logic st, input logic [31:0] want);
    logic [31:0] e;
    pc.curAddress = cur;
    pc.condAddr19 = c19;
    pc.brAddr26   = b26;
    pc.UncondBr   = ub;
    pc.brTaken    = bt;
    rst           = rs;
`ifdef PC_STALL_EN
    pc.stall      = st;
`endif
    sb.push_back(want);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(tag, pc.address, e);
    exp_pc = e;
  endtask

  initial begin
    logic [31:0] cur;
    logic [18:0] c19;
    logic [25:0] b26;
    logic ub, bt;
    nchk = 0;
    npass = 0;
    exp_pc = '0;
    rst = 1'b1;
    pc.curAddress = '0;
    pc.condAddr19 = '0;
    pc.brAddr26 = '0;
    pc.UncondBr = 1'b0;
    pc.brTaken = 1'b0;
`ifdef PC_STALL_EN
    pc.stall = 1'b0;
`endif
    @(negedge clk);

    step("reset", 32'h0, 19'h0, 26'h0, 0, 0, 1, 0, 32'h0);
    step("seq", 32'h0, 19'h0, 26'h0, 0, 0, 0, 0, 32'h4);
    step("cb_pos", 32'h0, 19'h00001, 26'h0, 0, 1, 0, 0, 32'h4);
    step("cb_neg", 32'h100, 19'h7FFFF, 26'h0, 0, 1, 0, 0, 32'hFC);
    step("b_pos", 32'h0, 19'h0, 26'h0000002, 1, 1, 0, 0, 32'h8);
    step("b_ext", 32'h0, 19'h0, 26'h2000000, 1, 1, 0, 0, 32'hF800_0000);
    step("ub_ign", 32'h40, 19'h0, 26'h0000002, 1, 0, 0, 0, 32'h44);
    step("bt_on", 32'h40, 19'h00010, 26'h0, 0, 1, 0, 0, 32'h80);
    step("bt_off", 32'h40, 19'h00010, 26'h0, 0, 0, 0, 0, 32'h44);
    step("wrap", 32'hFFFF_FFFC, 19'h0, 26'h0, 0, 0, 0, 0, 32'h0);
    step("unalign", 32'h0000_0101, 19'h0, 26'h0, 0, 0, 0, 0, 32'h105);
    step("cb_min", 32'h0010_0000, 19'h40000, 26'h0, 0, 1, 0, 0,
         32'h0000_0000);
    step("rst_pri", 32'h100, 19'h1, 26'h3, 1, 1, 1, 0, 32'h0);

    // Input changes between edges must not reach the register.
    step("pre_mid", 32'h200, 19'h0, 26'h0, 0, 0, 0, 0, 32'h204);
    #1;
    pc.curAddress = 32'hDEAD_0000;
    pc.brTaken = 1'b1;
    #1;
    chk("mid_edge", pc.address, exp_pc);

    for (int i = 0; i < 20; i++) begin
      cur = $urandom;
      c19 = 19'($urandom);
      b26 = 26'($urandom);
      ub  = 1'($urandom);
      bt  = 1'($urandom);
      step("rand", cur, c19, b26, ub, bt, 0, 0,
           model(cur, c19, b26, ub, bt));
    end

`ifdef PC_STALL_EN
    step("st_pre", 32'h4, 19'h0, 26'h0, 0, 0, 0, 0, 32'h8);
    step("stall", 32'h8, 19'h0, 26'h0, 0, 0, 0, 1, 32'h8);
    step("stall2", 32'h8, 19'h5, 26'h0, 0, 1, 0, 1, 32'h8);
    step("release", 32'h8, 19'h0, 26'h0, 0, 0, 0, 0, 32'hC);
    step("st_rst", 32'h8, 19'h0, 26'h0, 0, 0, 1, 1, 32'h0);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
